background_fill: RTL
====================

// Module: background_fill
//
// PURPOSE
//   Write-side engine for background_ram. On a start pulse, sweeps every pixel of the
//   WIDTH x HEIGHT background frame and writes a two-tone sky/floor image.
//   Rows above a programmable horizon get sky_color; the remaining rows get floor_color.
//   Drives the RAM's din/waddr/we port directly, one pixel per clock.
//   A pause input lets other writers (e.g. the rasterizer) take the RAM write port.
//
// PARAMETERS
//   NUMBER_COLORS  10   palette size; colour width CW = $clog2(NUMBER_COLORS)+1 (matches RAM)
//   WIDTH          320  frame width in pixels (x range 0..WIDTH-1)
//   HEIGHT         240  frame height in pixels (y range 0..HEIGHT-1)
//
// PORTS
//   clk          in   1                        system clock, rising edge
//   rst_n        in   1                        synchronous reset, active low
//   start        in   1                        begin a fill; sampled only in IDLE
//   pause        in   1                        while 1 in FILL: no write, counters hold
//   sky_color    in   CW                       colour for rows y < horizon
//   floor_color  in   CW                       colour for rows y >= horizon
//   horizon      in   8                        first floor row; >= HEIGHT means all sky
//   busy         out  1                        1 while in FILL
//   done         out  1                        one-cycle pulse after the last write
//   we           out  1                        RAM write enable
//   waddr        out  $clog2(WIDTH*HEIGHT)     RAM write address = y + HEIGHT*x
//   din          out  CW                       RAM write data
//
// BEHAVIOUR
//   - Reset (rst_n=0 at a clk edge) sets state=IDLE and busy=done=we=0, waddr=0, din=0.
//     Reset mid-fill abandons the sweep immediately. No further writes occur.
//   - All outputs are registered. The design uses no combinational path from input to output.
//   - FSM states: IDLE, FILL, DONE.
//   - IDLE: if start=1 at an edge, latch sky_color, floor_color and horizon into internal
//     registers, clear the x, y and address counters, go to FILL, and set busy=1.
//     Inputs that change after the latch do not affect the current fill.
//   - FILL, pause=0: each cycle output we=1, waddr=addr_cnt, din=(y<hz_l)?sky_l:floor_l.
//     Then increment y. When y=HEIGHT-1, set y=0 and increment x.
//     addr_cnt increments by 1 each cycle, so waddr runs strictly sequentially 0..WIDTH*HEIGHT-1.
//     This matches the RAM's column-major mapping y + HEIGHT*x.
//     An internal check requires addr_cnt == y + HEIGHT*x at all times.
//   - FILL, pause=1: we=0 on the next cycle. The x, y and address counters hold.
//     waddr and din hold their last values. The sweep resumes exactly where it stopped.
//   - The write with x=WIDTH-1, y=HEIGHT-1 is the last one. The next state is DONE.
//   - DONE: lasts one cycle. Outputs we=0, busy=0, done=1, then the FSM returns to IDLE.
//     A start pulse in the DONE cycle is ignored. A new start is accepted from IDLE.
//   - start while busy (FILL) or in DONE is ignored. It does not restart the sweep.
//   - Timing: start is sampled at edge 0. The first write (waddr=0) is visible after edge 1.
//     With no pause, the last write is visible after edge WIDTH*HEIGHT.
//     done=1 is visible after edge WIDTH*HEIGHT+1.
//     Each paused cycle adds one cycle to the sweep.
//   - horizon=0 gives an all-floor frame. horizon>=HEIGHT (240..255) gives an all-sky frame.
//   - Colours pass through unmodified. Range checking against NUMBER_COLORS is the
//     caller's job.
//
// TESTING
//   1 horizon=120, sky=3, floor=7, start pulse, no pause -> exactly 76800 writes.
//     waddr runs 0..76799 in order. din=3 when (waddr%240)<120, otherwise 7.
//     done pulses once, one cycle after waddr=76799.
//   2 horizon=0, then horizon=240, then horizon=255 -> every din=floor, then every din=sky
//     for both 240 and 255. Model a RAM and compare it pixel by pixel.
//   3 During the fill, assert pause for 5 cycles at waddr=1000 -> we=0 for 5 cycles.
//     The next write is waddr=1001 with no gaps or repeats. done arrives 5 cycles later.
//   4 Pulse start at waddr=500 with new colours, and again in the DONE cycle -> both
//     ignored. The sweep and its colours are unchanged. A start in the following IDLE
//     begins a new fill.
//   5 Assert rst_n=0 for one edge at waddr=40000 -> the next cycle shows we=0, busy=0,
//     done=0, waddr=0. No writes follow until the next start.
//   6 Change sky_color, floor_color and horizon every cycle during FILL -> din still
//     follows the values latched at start.

Source files
------------

// File: rtl/background_fill.sv
// Sky/floor frame writer: one column-major pixel per clock after start, done one cycle after the last write.
// Registered outputs only; pause stalls the sweep in place (we=0, counters and waddr/din hold).
module background_fill #(
  parameter  int NUMBER_COLORS = 10,
  parameter  int WIDTH         = 320,
  parameter  int HEIGHT        = 240,
  localparam int CW            = $clog2(NUMBER_COLORS) + 1,
  localparam int AW            = $clog2(WIDTH * HEIGHT)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_pause,
  input  logic [CW-1:0] i_sky_color,
  input  logic [CW-1:0] i_floor_color,
  input  logic [7:0]    i_horizon,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [CW-1:0] o_din
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CNTW  = $clog2(TOTAL + 1);
  localparam int XW    = $clog2(WIDTH + 1);
  localparam int YW    = $clog2(HEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t        r_state, w_state;
  logic [XW-1:0] r_x, w_x;
  logic [YW-1:0] r_y, w_y;
  logic [CNTW-1:0] r_addr, w_addr;
  logic [CW-1:0] r_sky, w_sky, r_floor, w_floor;
  logic [7:0]    r_hz, w_hz;
  logic          r_we, w_we, r_busy, w_busy, r_done, w_done;
  logic [AW-1:0] r_waddr, w_waddr;
  logic [CW-1:0] r_din, w_din;
  logic          w_last_row;

  // The counters run one step past the last pixel (x=WIDTH, y=0, addr=TOTAL); that
  // terminal value is what retires FILL, so the address/x/y relation holds throughout.
  always_comb begin
    w_state    = r_state;
    w_x        = r_x;
    w_y        = r_y;
    w_addr     = r_addr;
    w_sky      = r_sky;
    w_floor    = r_floor;
    w_hz       = r_hz;
    w_we       = 1'b0;
    w_waddr    = r_waddr;
    w_din      = r_din;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_last_row = (r_y == YW'(HEIGHT - 1));
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_sky   = i_sky_color;
          w_floor = i_floor_color;
          w_hz    = i_horizon;
          w_x     = '0;
          w_y     = '0;
          w_addr  = '0;
          w_busy  = 1'b1;
          w_state = S_FILL;
        end
      end
      S_FILL: begin
        if (r_addr == CNTW'(TOTAL)) begin
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = S_DONE;
        end else if (!i_pause) begin
          w_we    = 1'b1;
          w_waddr = r_addr[AW-1:0];
          w_din   = (32'(r_y) < 32'(r_hz)) ? r_sky : r_floor;
          w_addr  = r_addr + CNTW'(1);
          if (w_last_row) begin
            w_y = '0;
            w_x = r_x + XW'(1);
          end else begin
            w_y = r_y + YW'(1);
          end
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_addr  <= '0;
      r_sky   <= '0;
      r_floor <= '0;
      r_hz    <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_din   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_x     <= w_x;
      r_y     <= w_y;
      r_addr  <= w_addr;
      r_sky   <= w_sky;
      r_floor <= w_floor;
      r_hz    <= w_hz;
      r_we    <= w_we;
      r_waddr <= w_waddr;
      r_din   <= w_din;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (r_addr == CNTW'(r_y) + CNTW'(HEIGHT) * CNTW'(r_x));
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_we    = r_we;
  assign o_waddr = r_waddr;
  assign o_din   = r_din;

endmodule
